// File: rtl/regwb_pkg.sv
// Shared defaults and address decode helper for the register-file write-back arbiter.
package regwb_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_REGBITS = 3;
  localparam int DEF_NREQ    = 2;

  localparam int MAX_REGBITS = 8;
  localparam int MAX_REGS    = 2 ** MAX_REGBITS;

  // Callers truncate the result to their own register count.
  function automatic logic [MAX_REGS-1:0] addr_onehot(input logic [MAX_REGBITS-1:0] addr);
    logic [MAX_REGS-1:0] mask;
    mask = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first valid requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PTRW = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PTRW-1:0] ptr,
  output logic [NREQ-1:0] grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter feeding one registered register-file write port.
// Optional simulation trace of each write: define REGWB_TRACE_EN.
module regfile_wb_arbiter
  import regwb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int REGBITS = DEF_REGBITS,
  parameter int NREQ    = DEF_NREQ
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*REGBITS-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    wb_hold,
  output logic                    regwrite,
  output logic [REGBITS-1:0]      wa,
  output logic [WIDTH-1:0]        wd,
  output logic [2**REGBITS-1:0]   pend_mask
);

  localparam int NREGS = 2 ** REGBITS;
  localparam int PTRW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [REGBITS-1:0] addr_arr [NREQ];
  logic [WIDTH-1:0]   data_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign addr_arr[gi] = req_addr[gi*REGBITS +: REGBITS];
      assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic [PTRW-1:0]    rr_ptr_reg;
  logic [PTRW-1:0]    rr_ptr_next;
  logic [NREQ-1:0]    grant;
  logic [PTRW-1:0]    gidx;
  logic               transfer;
  logic               regwrite_reg;
  logic [REGBITS-1:0] wa_reg;
  logic [WIDTH-1:0]   wd_reg;

  rr_arbiter #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_arb (
    .valid (req_valid),
    .ptr   (rr_ptr_reg),
    .grant (grant)
  );

  assign req_ready = (reset || wb_hold) ? '0 : grant;
  assign transfer  = |req_ready;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gidx = PTRW'(i);
    end
  end

  assign rr_ptr_next = (gidx == PTRW'(NREQ - 1)) ? '0 : gidx + 1'b1;

  // Address 0 still consumes the grant but never raises the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg   <= '0;
      regwrite_reg <= 1'b0;
      wa_reg       <= '0;
      wd_reg       <= '0;
    end else if (transfer) begin
      rr_ptr_reg   <= rr_ptr_next;
      regwrite_reg <= (addr_arr[gidx] != '0);
      wa_reg       <= addr_arr[gidx];
      wd_reg       <= data_arr[gidx];
    end else begin
      regwrite_reg <= 1'b0;
    end
  end

  assign regwrite  = regwrite_reg;
  assign wa        = wa_reg;
  assign wd        = wd_reg;
  assign pend_mask = regwrite_reg ? NREGS'(addr_onehot(MAX_REGBITS'(wa_reg))) : '0;

`ifdef REGWB_TRACE_EN
  logic [PTRW-1:0] src_reg;

  always_ff @(posedge clk) begin
    if (reset) src_reg <= '0;
    else if (transfer) src_reg <= gidx;
  end

  always_ff @(posedge clk) begin
    if (!reset && regwrite_reg)
      $display("regwb: req=%0d wa=%0d wd=0x%0h", src_reg, wa_reg, wd_reg);
  end
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of each register and write-data bus.
REQ-002 Parameter REGBITS, default 3: register address width; the file holds 2**REGBITS registers.
REQ-003 Parameter NREQ, default 2, legal range 2..8: number of write-back requesters.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port req_valid  input  NREQ: bit i high = requester i presents a write.
REQ-007 Port req_addr  input  NREQ*REGBITS: requester i address in slice [i*REGBITS +: REGBITS].
REQ-008 Port req_data  input  NREQ*WIDTH: requester i data in slice [i*WIDTH +: WIDTH].
REQ-009 Port req_ready  output  NREQ: one-hot or zero; bit i high = requester i accepted this cycle.
REQ-010 Port wb_hold  input  1: high = no new grant this cycle.
REQ-011 Port regwrite  output  1: registered write strobe to the register file.
REQ-012 Port wa  output  REGBITS: registered write address.
REQ-013 Port wd  output  WIDTH: registered write data.
REQ-014 Port pend_mask  output  2**REGBITS: bit k high = a write to register k is in the output stage.

Function
REQ-015 Handshake: a transfer from requester i occurs when req_valid[i] and req_ready[i] are both high in the same cycle.
REQ-016 req_ready is combinational from req_valid, wb_hold and the round-robin pointer; it is all-zero when wb_hold is high or no valid is high.
REQ-017 Arbitration is round-robin: the search starts at pointer rr_ptr and proceeds upward with wrap modulo NREQ; the first valid requester is granted.
REQ-018 After a grant to requester g, rr_ptr becomes (g+1) mod NREQ on the next edge; rr_ptr is unchanged when no grant occurs.
REQ-019 Latency: a transfer accepted in cycle N drives regwrite, wa and wd in cycle N+1; back-to-back transfers sustain one write per cycle.
REQ-020 A transfer to address 0 is accepted and consumes the grant, but regwrite stays low in cycle N+1, because register 0 is hardwired to zero.
REQ-021 When there is no transfer in cycle N, regwrite is low in cycle N+1; wa and wd hold their previous values.
REQ-022 pend_mask is the one-hot decode of wa when regwrite is high, and zero otherwise.
REQ-023 A requester holding valid high without ready shall keep addr and data stable; the arbiter does not latch unaccepted requests.
REQ-024 Fairness: with all NREQ valids held high continuously, each requester is granted exactly once in every NREQ consecutive cycles.
REQ-025 wb_hold asserted while a write sits in the output stage does not cancel that write; it only blocks new grants.

Reset
REQ-026 While reset is high: regwrite=0, wa=0, wd=0, rr_ptr=0, pend_mask=0 and req_ready=0, regardless of req_valid.
REQ-027 A reset asserted in the same cycle as a transfer discards that transfer: no regwrite in the following cycle.

Configuration
REQ-028 Macro REGWB_TRACE_EN: when defined, the block prints, on every cycle with regwrite high, the requester index, wa and wd in simulation.
REQ-029 Without REGWB_TRACE_EN, the block contains no display statements; synthesizable behaviour is identical either way.

Structure
REQ-030 Package regwb_pkg holds the default WIDTH, REGBITS and NREQ constants and a function that decodes an address to a one-hot mask.
REQ-031 Sub-module rr_arbiter (NREQ-wide, pointer input, one-hot grant output, combinational) implements the round-robin search; the top holds rr_ptr and the output stage.

Verification
REQ-032 Reset, then req_valid=01, req_addr0=3, req_data0=0x5A -> req_ready=01 in cycle N; in cycle N+1, regwrite=1, wa=3, wd=0x5A, pend_mask=0x08.
REQ-033 Both valids high for 4 cycles from reset -> grant order 0,1,0,1; four consecutive regwrite pulses.
REQ-034 Requester 1 writes address 0 with data 0xFF -> req_ready[1]=1, regwrite=0 next cycle, pend_mask=0.
REQ-035 wb_hold=1 with both valids high for 3 cycles -> req_ready=00 and no regwrite; release wb_hold -> requester rr_ptr (0) is granted first.
REQ-036 reset asserted in the same cycle as an accepted write to address 5 -> regwrite=0, wa=0, wd=0 in the next cycle.
REQ-037 NREQ=3 with only requesters 0 and 2 valid -> grants alternate 0,2,0,2; requester 1 never receives ready.
